mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-master, one-slave arbiter for the req/gnt/rvalid memory bus. It lets two cores (or a core's instruction and data ports) share a single memory. It grants requests round-robin and holds the selection stable while a request waits for grant. A small in-order ID FIFO tracks outstanding transactions so each response is routed back to the master that issued it. It sits between the core bus ports and the memory/interconnect slave port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_OUT, 2, maximum outstanding (granted, not yet responded) transactions; 1..4
- clk  in  1  clock, rising edge
- res  in  1  reset, asynchronous, active-low
- m0_req, m1_req  in  1  master request, held until granted
- m0_we, m1_we  in  1  write enable (1 = write)
- m0_be, m1_be  in  DATA_W/8  byte enables
- m0_addr, m1_addr  in  ADDR_W  address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_gnt, m1_gnt  out  1  grant to master
- m0_rvalid, m1_rvalid  out  1  response valid to master
- m0_rdata, m1_rdata  out  DATA_W  read data; 0 when not the response owner
- s_req  out  1  request to slave
- s_we, s_be, s_addr, s_wdata  out  as master  attributes of the selected master
- s_gnt  in  1  slave grant, may depend combinationally on s_req
- s_rvalid  in  1  slave response; exactly one per granted transaction, in order, at least 1 cycle after gnt
- s_rdata  in  DATA_W  slave read data
- err  out  1  sticky: s_rvalid received with FIFO empty

## Operation
- State registers:
  - lock (1b): a request is pending at the slave without grant.
  - owner (1b): master that holds the lock.
  - last (1b): most recently granted master.
  - FIFO of master IDs, depth MAX_OUT.
  - count, width clog2(MAX_OUT+1).
  - err.
- Reset: lock=0, owner=0, last=1 (m0 wins first tie), count=0, FIFO pointers=0, err=0.
- Selection (combinational from registers and requests):
  - If lock, sel=owner.
  - Otherwise, if exactly one master requests, sel = that master.
  - If both request, sel = ~last.
  - If neither requests, sel=last and s_req=0.
- Presentation:
  - s_req = req[sel] & (count < MAX_OUT).
  - s_we/s_be/s_addr/s_wdata = attributes[sel].
  - When full, s_req=0 and lock is not set.
- Grant: m{sel}_gnt = s_req & s_gnt; the other master's gnt = 0.
- On a granted cycle (s_req & s_gnt):
  - push sel into the FIFO;
  - last <= sel;
  - lock <= 0.
- On s_req & ~s_gnt: lock <= 1, owner <= sel. While lock is set, neither the selection nor the presented attributes change.
- Response routing:
  - When s_rvalid and count>0: head ID h; m{h}_rvalid=1, m{h}_rdata=s_rdata; pop.
  - The non-owner master's rvalid=0 and rdata=0.
  - Writes also receive rvalid with don't-care rdata, which is forwarded as-is.
- Stray response: s_rvalid with count==0 gives no master rvalid and sets err <= 1. err clears only on reset.
- count arithmetic:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Never exceeds MAX_OUT and never underflows.
  - FIFO pointers wrap modulo MAX_OUT.
- A master that drops req while locked violates the bus protocol; behaviour is undefined and not checked.

## Timing
- Grant latency: combinational. gnt is returned in the same cycle as s_gnt, so zero arbiter cycles are added.
- Response latency: s_rvalid → m*_rvalid combinationally, same cycle.
- Back-to-back throughput: one grant per cycle while count<MAX_OUT.
- Full boundary: a pop in cycle N frees a slot for s_req in cycle N+1, not cycle N. The full check uses registered count.
- Reset asserted mid-transaction:
  - All state clears immediately, and all outputs go to 0 combinationally from the cleared state with req low.
  - The slave must be reset together with the arbiter; a late response after reset sets err.
- All outputs after reset with all inputs 0: 0 (err=0).

## Test plan
1. Round-robin fairness:
   - Stimulus: m0_req and m1_req held high; s_gnt=1 always; s_rvalid one cycle after each gnt.
   - Required: grants alternate m0, m1, m0, m1…, m0 first after reset; each rvalid goes to the master granted 1 cycle earlier.
2. Lock stability:
   - Stimulus: m1 requests alone at addr 0x100 with s_gnt=0 for 3 cycles; m0 raises req in cycle 2; s_gnt=1 in cycle 4.
   - Required: s_addr stays 0x100 throughout and m1_gnt fires in cycle 4; m0 is granted in cycle 5.
3. Outstanding limit (MAX_OUT=2):
   - Stimulus: m0 issues reads with s_gnt=1 and no s_rvalid.
   - Required: two grants, then s_req=0.
   - Stimulus continues: one s_rvalid with s_rdata=0xDEADBEEF.
   - Required: m0_rdata=0xDEADBEEF in that cycle and s_req=1 in the next cycle.
4. Interleaved routing:
   - Stimulus: grant order m0, m1; responses 0x11111111 then 0x22222222.
   - Required: m0 gets 0x11111111 and m1 gets 0x22222222; m1_rdata=0 during m0's response.
5. Simultaneous push/pop:
   - Stimulus: count=1, with a grant and a response in the same cycle.
   - Required: count remains 1 and the FIFO order is preserved.
6. Error and reset:
   - Stimulus: s_rvalid with an empty FIFO.
   - Required: err=1, no m*_rvalid.
   - Stimulus continues: assert res low mid-lock.
   - Required: err=0, lock=0, count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the req/gnt/rvalid memory bus.
// An in-order ID FIFO remembers which master owns each outstanding transaction
// so that every slave response is steered back to its issuer.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                  clk,
  input  logic                  res,
  // master 0
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [DATA_W/8-1:0]   m0_be,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  // master 1
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [DATA_W/8-1:0]   m1_be,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  // slave
  output logic                  s_req,
  output logic                  s_we,
  output logic [DATA_W/8-1:0]   s_be,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  input  logic                  s_gnt,
  input  logic                  s_rvalid,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic                  err
);

  localparam int unsigned CntW = $clog2(MAX_OUT + 1);
  localparam int unsigned PtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUT);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUT - 1);

  logic               lock_q, lock_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic [MAX_OUT-1:0] fifo_q, fifo_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;

  logic sel;
  logic req_sel;
  logic full;
  logic push;
  logic pop;
  logic head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Pick the master to present: the locked owner, else round-robin on requests.
  always_comb begin
    sel = last_q;
    if (lock_q) begin
      sel = owner_q;
    end else begin
      unique case ({m1_req, m0_req})
        2'b01:   sel = 1'b0;
        2'b10:   sel = 1'b1;
        2'b11:   sel = ~last_q;
        default: sel = last_q;
      endcase
    end
  end

  // Slave-side presentation, grant fan-out and response routing.
  always_comb begin
    req_sel = sel ? m1_req : m0_req;
    // Registered count only: a pop frees a slot for the following cycle.
    full    = (count_q == MaxCnt);
    s_req   = req_sel & ~full;
    s_we    = sel ? m1_we    : m0_we;
    s_be    = sel ? m1_be    : m0_be;
    s_addr  = sel ? m1_addr  : m0_addr;
    s_wdata = sel ? m1_wdata : m0_wdata;

    push   = s_req & s_gnt;
    m0_gnt = push & ~sel;
    m1_gnt = push & sel;

    head      = fifo_q[rd_ptr_q];
    pop       = s_rvalid & (count_q != '0);
    m0_rvalid = pop & ~head;
    m1_rvalid = pop & head;
    m0_rdata  = m0_rvalid ? s_rdata : '0;
    m1_rdata  = m1_rvalid ? s_rdata : '0;

    err = err_q;
  end

  // Next-state for lock, round-robin pointer, ID FIFO, occupancy and error flag.
  always_comb begin
    lock_d   = lock_q;
    owner_d  = owner_q;
    last_d   = last_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;

    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      last_d           = sel;
      lock_d           = 1'b0;
    end else if (s_req) begin
      lock_d  = 1'b1;
      owner_d = sel;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Response with nothing outstanding is a protocol error; sticky until reset.
    if (s_rvalid && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  // State registers; last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      lock_q   <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      err_q    <= 1'b0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      err_q    <= err_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
